// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if
//   Signal bundle between an instruction fetch source and the dual-issue
//   scheduler.
//
//   fetch_valid   fetch -> sched  instruction pair present
//   fetch_ready   sched -> fetch  pair accepted on an edge with fetch_valid
//   instr0_in     fetch -> sched  older instruction of the pair
//   instr1_in     fetch -> sched  younger instruction of the pair
//   flush         fetch -> sched  discard any held instruction
//   issue0_o      sched -> exec   slot-0 issue, 16'h0 = nop
//   issue1_o      sched -> exec   slot-1 issue, 16'h0 = nop
//   single_issue  sched -> exec   pair split, younger instruction held
//   stall         sched -> exec   candidate blocked by the scoreboard
//   busy_regs     sched -> exec   bitmap of registers still being produced
//
//   The master modport is the fetch/testbench side; the slave modport is the
//   scheduler side.
interface issue_scheduler_if #(
  parameter int NREG = 8
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [15:0]     instr0_in;
  logic [15:0]     instr1_in;
  logic            flush;
  logic [15:0]     issue0_o;
  logic [15:0]     issue1_o;
  logic            single_issue;
  logic            stall;
  logic [NREG-1:0] busy_regs;

  modport master (
    output fetch_valid, instr0_in, instr1_in, flush,
    input  fetch_ready, issue0_o, issue1_o, single_issue, stall, busy_regs
  );

  modport slave (
    input  fetch_valid, instr0_in, instr1_in, flush,
    output fetch_ready, issue0_o, issue1_o, single_issue, stall, busy_regs
  );
endinterface

// File: rtl/issue_scheduler.sv
// issue_scheduler
//   In-order dual-issue scheduler with a per-register countdown scoreboard.
//   A pair (older A, younger B) is accepted when A is free of scoreboard
//   hazards. A always issues in slot 0; B issues in slot 1 unless it is
//   hazarded or depends on A, in which case B is held and issued alone later.
//
//   Instruction format: [15:12] opcode (0 = nop), [11] imm (reads rs1 only),
//   [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] ignored.
//
// Ports
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave side of issue_scheduler_if (fetch handshake, flush,
//               registered issue slots, single_issue, stall, busy_regs)
//
// Parameters
//   LAT    cycles a destination stays busy after issue (2..7)
//   NREG   number of architectural registers (3-bit register fields)
//
// Configuration
//   ISSUE_SCHED_FORWARD_EN  when defined, issued destinations load LAT-1 so
//                           a dependent issues one cycle earlier.
module issue_scheduler #(
  parameter int LAT  = 3,
  parameter int NREG = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  issue_scheduler_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

`ifdef ISSUE_SCHED_FORWARD_EN
  localparam logic [2:0] LOAD_VAL = 3'(LAT - 1);
`else
  localparam logic [2:0] LOAD_VAL = 3'(LAT);
`endif

  state_t          state_q, state_d;
  logic [15:0]     hold_q, hold_d;
  logic [15:0]     issue0_q, issue0_d;
  logic [15:0]     issue1_q, issue1_d;
  logic            single_q, single_d;
  logic            stall_q, stall_d;
  logic [2:0]      sb_q [NREG];
  logic [2:0]      sb_d [NREG];
  logic [NREG-1:0] busy;
  logic            hazA, hazB, hazH, conflictAB;

  // True when an instruction with these fields sources register r.
  function automatic logic readsReg(input logic [3:0] op, input logic imm,
                                    input logic [2:0] rs1, input logic [2:0] rs2,
                                    input logic [2:0] r);
    return (op != 4'd0) && ((rs1 == r) || (!imm && (rs2 == r)));
  endfunction

  // A nop never hazards; otherwise any sourced register still busy blocks it.
  function automatic logic hazard(input logic [3:0] op, input logic imm,
                                  input logic [2:0] rs1, input logic [2:0] rs2,
                                  input logic [NREG-1:0] b);
    return (op != 4'd0) && (b[rs1] || (!imm && b[rs2]));
  endfunction

  // A register is busy while its counter is above one, so the last counted
  // cycle already lets a dependent through.
  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++) begin
      busy[r] = (sb_q[r] > 3'd1);
    end
  end

  assign hazA = hazard(bus.instr0_in[15:12], bus.instr0_in[11],
                       bus.instr0_in[7:5], bus.instr0_in[4:2], busy);
  assign hazB = hazard(bus.instr1_in[15:12], bus.instr1_in[11],
                       bus.instr1_in[7:5], bus.instr1_in[4:2], busy);
  assign hazH = hazard(hold_q[15:12], hold_q[11], hold_q[7:5], hold_q[4:2], busy);

  // RAW either way or WAW between the two halves of the pair.
  assign conflictAB = (bus.instr0_in[15:12] != 4'd0) && (bus.instr1_in[15:12] != 4'd0) &&
                      (readsReg(bus.instr1_in[15:12], bus.instr1_in[11], bus.instr1_in[7:5],
                                bus.instr1_in[4:2], bus.instr0_in[10:8]) ||
                       readsReg(bus.instr0_in[15:12], bus.instr0_in[11], bus.instr0_in[7:5],
                                bus.instr0_in[4:2], bus.instr1_in[10:8]) ||
                       (bus.instr0_in[10:8] == bus.instr1_in[10:8]));

  assign bus.fetch_ready = (state_q == EMPTY) && !bus.flush && !hazA;

  // Issue decision for the coming edge. Flush overrides everything; outputs
  // default to nop with both flags clear.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    issue0_d = 16'h0;
    issue1_d = 16'h0;
    single_d = 1'b0;
    stall_d  = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
      hold_d  = 16'h0;
    end else if (state_q == HELD) begin
      if (hazH) begin
        stall_d = 1'b1;
      end else begin
        issue0_d = hold_q;
        hold_d   = 16'h0;
        state_d  = EMPTY;
      end
    end else if (bus.fetch_valid) begin
      if (hazA) begin
        stall_d = 1'b1;
      end else begin
        issue0_d = bus.instr0_in;
        if (!hazB && !conflictAB) begin
          issue1_d = bus.instr1_in;
        end else begin
          hold_d   = bus.instr1_in;
          single_d = 1'b1;
          state_d  = HELD;
        end
      end
    end
  end

  // Scoreboard: destinations issued this edge reload, everything else
  // counts down to zero.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      sb_d[r] = 3'd0;
      if (((issue0_d[15:12] != 4'd0) && (issue0_d[10:8] == 3'(r))) ||
          ((issue1_d[15:12] != 4'd0) && (issue1_d[10:8] == 3'(r)))) begin
        sb_d[r] = LOAD_VAL;
      end else if (sb_q[r] != 3'd0) begin
        sb_d[r] = sb_q[r] - 3'd1;
      end
    end
  end

  // State, hold register, registered outputs and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      hold_q   <= 16'h0;
      issue0_q <= 16'h0;
      issue1_q <= 16'h0;
      single_q <= 1'b0;
      stall_q  <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        sb_q[r] <= 3'd0;
      end
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      issue0_q <= issue0_d;
      issue1_q <= issue1_d;
      single_q <= single_d;
      stall_q  <= stall_d;
      for (int r = 0; r < NREG; r++) begin
        sb_q[r] <= sb_d[r];
      end
    end
  end

  assign bus.issue0_o     = issue0_q;
  assign bus.issue1_o     = issue1_q;
  assign bus.single_issue = single_q;
  assign bus.stall        = stall_q;
  assign bus.busy_regs    = busy;

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler
//   Directed scenarios plus a randomized run of issue_scheduler, checked
//   against a reference model that tracks, per register, the edge number at
//   which it becomes readable again, and a queue holding a split-off
//   younger instruction.
module tb_issue_scheduler;
  localparam int LAT  = 3;
  localparam int NREG = 8;
`ifdef ISSUE_SCHED_FORWARD_EN
  localparam int LATEFF = LAT - 1;
`else
  localparam int LATEFF = LAT;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  issue_scheduler_if #(.NREG(NREG)) bus ();

  issue_scheduler #(.LAT(LAT), .NREG(NREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          readyAt [NREG];
  logic [15:0] heldQ [$];

  logic            gotReady, expReady, expSingle, expStall;
  logic [15:0]     exp0, exp1;
  logic [NREG-1:0] expBusy;

  // Model: register r may be read at edge e once e >= readyAt[r].
  function automatic bit isBusy(input int r, input int e);
    return e < readyAt[r];
  endfunction

  function automatic bit readsR(input logic [15:0] ins, input int r);
    if (ins[15:12] == 4'd0) return 1'b0;
    return (int'(ins[7:5]) == r) || (!ins[11] && (int'(ins[4:2]) == r));
  endfunction

  function automatic bit blocked(input logic [15:0] ins, input int e);
    if (ins[15:12] == 4'd0) return 1'b0;
    return isBusy(int'(ins[7:5]), e) || (!ins[11] && isBusy(int'(ins[4:2]), e));
  endfunction

  function automatic bit pairConflict(input logic [15:0] a, input logic [15:0] b);
    if (a[15:12] == 4'd0 || b[15:12] == 4'd0) return 1'b0;
    return readsR(b, int'(a[10:8])) || readsR(a, int'(b[10:8])) || (a[10:8] == b[10:8]);
  endfunction

  function automatic logic [15:0] randInstr();
    logic [15:0] x;
    if ($urandom_range(0, 4) == 0) return 16'h0;
    x[15:12] = 4'($urandom_range(1, 15));
    x[11]    = 1'($urandom_range(0, 1));
    x[10:8]  = 3'($urandom_range(1, 4));
    x[7:5]   = 3'($urandom_range(0, 4));
    x[4:2]   = 3'($urandom_range(0, 4));
    x[1:0]   = 2'($urandom_range(0, 3));
    return x;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < NREG; r++) readyAt[r] = 0;
    heldQ.delete();
  endtask

  // Predict the decision taken on the coming edge and advance the model.
  task automatic modelStep(input logic v, input logic [15:0] i0, input logic [15:0] i1,
                           input logic fl);
    int e;
    e = cyc + 1;
    expReady  = (heldQ.size() == 0) && !fl && !blocked(i0, e);
    exp0      = 16'h0;
    exp1      = 16'h0;
    expSingle = 1'b0;
    expStall  = 1'b0;
    if (fl) begin
      heldQ.delete();
    end else if (heldQ.size() != 0) begin
      if (blocked(heldQ[0], e)) expStall = 1'b1;
      else begin
        exp0 = heldQ[0];
        heldQ.delete();
      end
    end else if (v) begin
      if (blocked(i0, e)) expStall = 1'b1;
      else begin
        exp0 = i0;
        if (!blocked(i1, e) && !pairConflict(i0, i1)) exp1 = i1;
        else begin
          heldQ.push_back(i1);
          expSingle = 1'b1;
        end
      end
    end
    if (exp0[15:12] != 4'd0) readyAt[int'(exp0[10:8])] = e + LATEFF;
    if (exp1[15:12] != 4'd0) readyAt[int'(exp1[10:8])] = e + LATEFF;
  endtask

  // Drive one cycle (called just after a rising edge), sample fetch_ready
  // before the edge, then leave outputs ready to sample 1ns after it.
  task automatic applyStimulus(input logic v, input logic [15:0] i0, input logic [15:0] i1,
                               input logic fl);
    bus.fetch_valid = v;
    bus.instr0_in   = i0;
    bus.instr1_in   = i1;
    bus.flush       = fl;
    #1;
    gotReady = bus.fetch_ready;
    modelStep(v, i0, i1, fl);
    @(posedge clk);
    #1;
    cyc++;
    for (int r = 0; r < NREG; r++) expBusy[r] = (cyc + 1) < readyAt[r];
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic test_reset();
    bus.fetch_valid = 1'b0;
    bus.instr0_in   = 16'h0;
    bus.instr1_in   = 16'h0;
    bus.flush       = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    checks++; if (bus.issue0_o !== 16'h0) begin errors++; $display("[TB] FAIL reset_issue0 got=%h exp=0000", bus.issue0_o); end
    checks++; if (bus.issue1_o !== 16'h0) begin errors++; $display("[TB] FAIL reset_issue1 got=%h exp=0000", bus.issue1_o); end
    checks++; if (bus.single_issue !== 1'b0) begin errors++; $display("[TB] FAIL reset_single got=%b exp=0", bus.single_issue); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.busy_regs !== '0) begin errors++; $display("[TB] FAIL reset_busy got=%h exp=00", bus.busy_regs); end
    modelReset();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", bus.fetch_ready); end
  endtask

  task automatic test_independent_pair();
    applyStimulus(1'b1, 16'h114C, 16'h15DC, 1'b0);
    checks++; if (gotReady !== 1'b1) begin errors++; $display("[TB] FAIL indep_ready got=%b exp=1", gotReady); end
    checks++; if (bus.issue0_o !== 16'h114C) begin errors++; $display("[TB] FAIL indep_issue0 got=%h exp=114c", bus.issue0_o); end
    checks++; if (bus.issue1_o !== 16'h15DC) begin errors++; $display("[TB] FAIL indep_issue1 got=%h exp=15dc", bus.issue1_o); end
    checks++; if (bus.single_issue !== 1'b0) begin errors++; $display("[TB] FAIL indep_single got=%b exp=0", bus.single_issue); end
    checks++; if (bus.busy_regs !== 8'h22) begin errors++; $display("[TB] FAIL indep_busy got=%h exp=22", bus.busy_regs); end
    idle(LAT + 1);
  endtask

  task automatic test_dependent_pair();
    int found;
    found = 0;
    applyStimulus(1'b1, 16'h114C, 16'h2C20, 1'b0);
    checks++; if (bus.issue0_o !== 16'h114C) begin errors++; $display("[TB] FAIL dep_issue0 got=%h exp=114c", bus.issue0_o); end
    checks++; if (bus.issue1_o !== 16'h0) begin errors++; $display("[TB] FAIL dep_issue1 got=%h exp=0000", bus.issue1_o); end
    checks++; if (bus.single_issue !== 1'b1) begin errors++; $display("[TB] FAIL dep_single got=%b exp=1", bus.single_issue); end
    checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("[TB] FAIL dep_ready got=%b exp=0", bus.fetch_ready); end
    for (int k = 1; k <= 10 && found == 0; k++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      if (bus.issue0_o === 16'h2C20) found = k;
      else begin
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL dep_stall k=%0d got=%b exp=1", k, bus.stall); end
      end
    end
    checks++; if (found != LATEFF) begin errors++; $display("[TB] FAIL dep_latency got=%0d exp=%0d (0 = never issued)", found, LATEFF); end
    idle(LAT + 1);
  endtask

  task automatic test_hazard_stall();
    applyStimulus(1'b1, 16'h114C, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'h2C20, 16'h0000, 1'b0);
    checks++; if (gotReady !== 1'b0) begin errors++; $display("[TB] FAIL haz_ready got=%b exp=0", gotReady); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL haz_stall got=%b exp=1", bus.stall); end
    checks++; if (bus.issue0_o !== 16'h0) begin errors++; $display("[TB] FAIL haz_issue0 got=%h exp=0000", bus.issue0_o); end
    checks++; if (bus.issue1_o !== 16'h0) begin errors++; $display("[TB] FAIL haz_issue1 got=%h exp=0000", bus.issue1_o); end
    idle(LAT + 1);
  endtask

  task automatic test_flush_held();
    applyStimulus(1'b1, 16'h114C, 16'h2C20, 1'b0);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
    checks++; if (bus.issue0_o !== 16'h0) begin errors++; $display("[TB] FAIL flush_issue0 got=%h exp=0000", bus.issue0_o); end
    checks++; if (bus.issue1_o !== 16'h0) begin errors++; $display("[TB] FAIL flush_issue1 got=%h exp=0000", bus.issue1_o); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall got=%b exp=0", bus.stall); end
    bus.flush = 1'b0;
    #1;
    checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready got=%b exp=1", bus.fetch_ready); end
    for (int k = 0; k < LAT + 2; k++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      checks++; if (bus.issue0_o === 16'h2C20) begin errors++; $display("[TB] FAIL flush_discard k=%0d got=%h exp=0000", k, bus.issue0_o); end
    end
  endtask

  task automatic test_reset_mid_held();
    applyStimulus(1'b1, 16'h114C, 16'h2C20, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.issue0_o !== 16'h0) begin errors++; $display("[TB] FAIL arst_issue0 got=%h exp=0000", bus.issue0_o); end
    checks++; if (bus.single_issue !== 1'b0) begin errors++; $display("[TB] FAIL arst_single got=%b exp=0", bus.single_issue); end
    checks++; if (bus.busy_regs !== '0) begin errors++; $display("[TB] FAIL arst_busy got=%h exp=00", bus.busy_regs); end
    @(posedge clk);
    cyc++;
    #1;
    modelReset();
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      checks++; if (bus.issue0_o !== 16'h0 || bus.stall !== 1'b0) begin
        errors++; $display("[TB] FAIL arst_after k=%0d issue0=%h stall=%b exp=0000/0", k, bus.issue0_o, bus.stall);
      end
    end
  endtask

  task automatic test_nop_pair();
    applyStimulus(1'b1, 16'h114C, 16'h15DC, 1'b0);
    applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b0);
    checks++; if (gotReady !== 1'b1) begin errors++; $display("[TB] FAIL nop_ready got=%b exp=1", gotReady); end
    checks++; if (bus.issue0_o !== 16'h0 || bus.issue1_o !== 16'h0) begin
      errors++; $display("[TB] FAIL nop_issue got=%h/%h exp=0000/0000", bus.issue0_o, bus.issue1_o);
    end
    checks++; if (bus.single_issue !== 1'b0) begin errors++; $display("[TB] FAIL nop_single got=%b exp=0", bus.single_issue); end
    checks++; if (bus.busy_regs !== expBusy) begin errors++; $display("[TB] FAIL nop_busy got=%h exp=%h", bus.busy_regs, expBusy); end
    idle(LAT + 1);
  endtask

  task automatic test_random();
    logic        v, fl;
    logic [15:0] i0, i1;
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 9) < 8);
      fl = ($urandom_range(0, 24) == 0);
      i0 = randInstr();
      i1 = randInstr();
      applyStimulus(v, i0, i1, fl);
      checks++; if (gotReady !== expReady) begin errors++; $display("[TB] FAIL rnd_ready n=%0d got=%b exp=%b", n, gotReady, expReady); end
      checks++; if (bus.issue0_o !== exp0) begin errors++; $display("[TB] FAIL rnd_issue0 n=%0d got=%h exp=%h", n, bus.issue0_o, exp0); end
      checks++; if (bus.issue1_o !== exp1) begin errors++; $display("[TB] FAIL rnd_issue1 n=%0d got=%h exp=%h", n, bus.issue1_o, exp1); end
      checks++; if (bus.single_issue !== expSingle) begin errors++; $display("[TB] FAIL rnd_single n=%0d got=%b exp=%b", n, bus.single_issue, expSingle); end
      checks++; if (bus.stall !== expStall) begin errors++; $display("[TB] FAIL rnd_stall n=%0d got=%b exp=%b", n, bus.stall, expStall); end
      checks++; if (bus.busy_regs !== expBusy) begin errors++; $display("[TB] FAIL rnd_busy n=%0d got=%h exp=%h", n, bus.busy_regs, expBusy); end
    end
  endtask

  initial begin
    $display("[TB] issue_scheduler bench, LAT=%0d effective latency=%0d", LAT, LATEFF);
    test_reset();
    test_independent_pair();
    test_dependent_pair();
    test_hazard_stall();
    test_flush_held();
    test_reset_mid_held();
    test_nop_pair();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
